evb_pic: RTL and testbench

Programmable interrupt controller that sits directly downstream of the EVB bus decoder and serves its PIC block slot. It collects up to 16 peripheral interrupt lines, synchronises them, and latches them as pending. It also applies a per-line enable mask, arbitrates by fixed priority, and drives one interrupt request to the processor. Software reads and writes its registers through the EVB command handshake: request is held until finish, and finish is held until request drops.

---
 rtl/evb_pic_if.sv | 22 ++
 rtl/evb_pic.sv | 172 +++++++++++++++++
 tb/tb_evb_pic.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/evb_pic_if.sv
// EVB command port of the PIC: level request/finish handshake with register address and data.
// Latency: none; this file only groups signals.
// Backpressure: request stays high until finish is seen, and finish stays high until request drops.
// Ports: master drives request/addr/wr/wr_data, slave drives finish/rd_data.
interface evb_pic_if;
    logic        pic_evb_cmd_request;
    logic [3:0]  pic_evb_cmd_addr;
    logic        pic_evb_cmd_wr;
    logic [31:0] pic_evb_cmd_wr_data;
    logic        pic_evb_cmd_finish;
    logic [31:0] pic_evb_cmd_rd_data;

    modport master (
        output pic_evb_cmd_request, pic_evb_cmd_addr, pic_evb_cmd_wr, pic_evb_cmd_wr_data,
        input  pic_evb_cmd_finish, pic_evb_cmd_rd_data
    );

    modport slave (
        input  pic_evb_cmd_request, pic_evb_cmd_addr, pic_evb_cmd_wr, pic_evb_cmd_wr_data,
        output pic_evb_cmd_finish, pic_evb_cmd_rd_data
    );
endinterface

// File: rtl/evb_pic.sv
// Interrupt controller: sync, pending latch, mask, fixed-priority claim/EOI, and one irq_out.
// Latency: a command completes with finish 2 clocks after request is sampled; irq_in reaches pending in 3 clocks and irq_out in 4.
// Backpressure: one command at a time; finish is held until request drops, and a new command needs request to have been low.
// Ports: clk, rst_n (async active-low), irq_in[NUM_IRQ], bus (evb_pic_if.slave), irq_out.
// Build option: PIC_EDGE_EN builds the EDGE register and rising-edge pending latches.
module evb_pic #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    evb_pic_if.slave           bus,
    output logic               irq_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic               finish_q, finish_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               irq_out_q, irq_out_d;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] inservice_q, inservice_d;
    logic [NUM_IRQ-1:0] edge_sel;
`ifdef PIC_EDGE_EN
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] claim_clr;
`endif

    logic               req;
    logic               access;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] claim_oh;
    logic [3:0]         claim_id;
    logic [NUM_IRQ-1:0] eoi_oh;

    // Write-data bits above the implemented lines carry no meaning.
    logic unused_wr_data;
    assign unused_wr_data = ^bus.pic_evb_cmd_wr_data[31:NUM_IRQ];

    assign req    = bus.pic_evb_cmd_request;
    // The access is skipped entirely when request has already dropped.
    assign access = (state_q == ST_ACCESS) && req;

`ifdef PIC_EDGE_EN
    assign edge_sel = edge_q;
`else
    assign edge_sel = '0;
`endif

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | ~req;
        rd_data_d   = rd_data_q;
        mask_d      = mask_q;
        inservice_d = inservice_q;
`ifdef PIC_EDGE_EN
        edge_d      = edge_q;
        claim_clr   = '0;
`endif

        eligible = pending_q & mask_q & ~inservice_q;
        // Isolate the lowest set bit: that line has the highest priority.
        claim_oh = eligible & (~eligible + 1'b1);
        claim_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) claim_id = 4'(i);
        end
        // Out-of-range EOI ids match no line and so clear nothing.
        for (int i = 0; i < NUM_IRQ; i++) begin
            eoi_oh[i] = (bus.pic_evb_cmd_wr_data[3:0] == 4'(i));
        end

        if (access) begin
            if (bus.pic_evb_cmd_wr) begin
                case (bus.pic_evb_cmd_addr)
                    4'd1:    mask_d      = bus.pic_evb_cmd_wr_data[NUM_IRQ-1:0];
                    4'd3:    inservice_d = inservice_q & ~eoi_oh;
`ifdef PIC_EDGE_EN
                    4'd4:    edge_d      = bus.pic_evb_cmd_wr_data[NUM_IRQ-1:0];
`endif
                    default: ;
                endcase
            end else begin
                case (bus.pic_evb_cmd_addr)
                    4'd0:    rd_data_d = 32'(pending_q);
                    4'd1:    rd_data_d = 32'(mask_q);
                    4'd2: begin
                        rd_data_d = '0;
                        if (|eligible) begin
                            rd_data_d   = {1'b1, 27'd0, claim_id};
                            inservice_d = inservice_q | claim_oh;
`ifdef PIC_EDGE_EN
                            claim_clr   = claim_oh;
`endif
                        end
                    end
                    4'd4:    rd_data_d = 32'(edge_sel);
                    4'd5:    rd_data_d = 32'(inservice_q);
                    default: rd_data_d = '0;
                endcase
            end
        end

`ifdef PIC_EDGE_EN
        // Edge lines: a new synced rise wins over a same-cycle claim clear.
        pending_d = (edge_q & ((pending_q & ~claim_clr) | (sync2_q & ~prev_q)))
                  | (~edge_q & sync2_q);
`else
        pending_d = sync2_q;
`endif

        irq_out_d = |eligible;

        case (state_q)
            ST_IDLE: begin
                if (req && armed_q) begin
                    state_d = ST_ACCESS;
                    armed_d = 1'b0;
                end
            end
            ST_ACCESS: state_d = req ? ST_DONE : ST_IDLE;
            ST_DONE:   if (!req) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        finish_d = (state_q == ST_DONE) && req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            finish_q    <= 1'b0;
            rd_data_q   <= '0;
            irq_out_q   <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            inservice_q <= '0;
`ifdef PIC_EDGE_EN
            edge_q      <= '0;
            prev_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            finish_q    <= finish_d;
            rd_data_q   <= rd_data_d;
            irq_out_q   <= irq_out_d;
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            inservice_q <= inservice_d;
`ifdef PIC_EDGE_EN
            edge_q      <= edge_d;
            prev_q      <= sync2_q;
`endif
        end
    end

    assign bus.pic_evb_cmd_finish  = finish_q;
    assign bus.pic_evb_cmd_rd_data = rd_data_q;
    assign irq_out                 = irq_out_q;

endmodule

// File: tb/tb_evb_pic.sv
// Directed bench for evb_pic: register access, priority claim/EOI, masking, edge mode, abort and reset.
// Latency: checks finish at exactly 2 clocks after the sampling edge and irq_out at 4 clocks after irq_in.
// Backpressure: holds request after finish and checks finish stays up, then drops it and checks finish falls.
module tb_evb_pic;
    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       irq_out;

    evb_pic_if bus();

    evb_pic #(.NUM_IRQ(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .bus     (bus.slave),
        .irq_out (irq_out)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One command; reads push their expected data to the scoreboard, popped when finish appears.
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                          input logic [31:0] exp, input int hold);
        int n;
        logic seen;
        logic [31:0] e;
        if (!wr) sb_q.push_back(exp);
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b1;
        bus.pic_evb_cmd_addr    = addr;
        bus.pic_evb_cmd_wr      = wr;
        bus.pic_evb_cmd_wr_data = data;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (bus.pic_evb_cmd_finish === 1'b1) seen = 1'b1;
        end
        check("finish_seen", 32'(seen), 32'd1);
        if (!wr && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (seen) check($sformatf("rd_data_a%0d", addr), bus.pic_evb_cmd_rd_data, e);
        end
        if (seen) begin
            // sampling edge E0 plus two more edges
            check("finish_latency", 32'(n), 32'd3);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("finish_hold", 32'(bus.pic_evb_cmd_finish), 32'd1);
            end
        end
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b0;
        @(posedge clk); #1;
        check("finish_drop", 32'(bus.pic_evb_cmd_finish), 32'd0);
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
        do_cmd(1'b1, addr, data, 32'd0, 0);
    endtask

    task automatic rd_reg(input logic [3:0] addr, input logic [31:0] exp);
        do_cmd(1'b0, addr, 32'd0, exp, 0);
    endtask

    task automatic pulse0();
        @(negedge clk); irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        int fin_seen;
        rst_n  = 1'b0;
        irq_in = '0;
        bus.pic_evb_cmd_request = 1'b0;
        bus.pic_evb_cmd_addr    = '0;
        bus.pic_evb_cmd_wr      = 1'b0;
        bus.pic_evb_cmd_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_finish", 32'(bus.pic_evb_cmd_finish), 32'd0);
        check("rst_rd_data", bus.pic_evb_cmd_rd_data, 32'd0);
        check("rst_irq_out", 32'(irq_out), 32'd0);
        rst_n = 1'b1;

        // Reset register values
        rd_reg(4'd0, 32'd0);
        rd_reg(4'd1, 32'd0);
        rd_reg(4'd5, 32'd0);
        rd_reg(4'd4, 32'd0);
        check("idle_irq_out", 32'(irq_out), 32'd0);

        // Handshake: long hold on a write, then readback
        do_cmd(1'b1, 4'd1, 32'h0000_0005, 32'd0, 4);
        rd_reg(4'd1, 32'h0000_0005);

        // Level mode priority and claim
        wr_reg(4'd1, 32'h0000_00FF);
        @(negedge clk); irq_in = 8'h0A;
        repeat (3) @(posedge clk); #1;
        check("irq_lat_3", 32'(irq_out), 32'd0);
        @(posedge clk); #1;
        check("irq_lat_4", 32'(irq_out), 32'd1);
        rd_reg(4'd0, 32'h0000_000A);
        // held claim must still claim only once
        do_cmd(1'b0, 4'd2, 32'd0, 32'h8000_0001, 3);
        rd_reg(4'd5, 32'h0000_0002);
        rd_reg(4'd2, 32'h8000_0003);
        rd_reg(4'd2, 32'h0000_0000);
        rd_reg(4'd5, 32'h0000_000A);
        rd_reg(4'd0, 32'h0000_000A);
        check("all_claimed_irq", 32'(irq_out), 32'd0);
        wr_reg(4'd3, 32'd1);
        check("eoi_rearm_irq", 32'(irq_out), 32'd1);
        rd_reg(4'd5, 32'h0000_0008);
        rd_reg(4'd2, 32'h8000_0001);
        wr_reg(4'd3, 32'd9);
        rd_reg(4'd5, 32'h0000_000A);
        wr_reg(4'd3, 32'd1);
        wr_reg(4'd3, 32'd3);
        rd_reg(4'd5, 32'h0000_0000);
        @(negedge clk); irq_in = '0;
        repeat (4) @(posedge clk);
        rd_reg(4'd0, 32'h0000_0000);
        check("level_low_irq", 32'(irq_out), 32'd0);

        // Masking
        wr_reg(4'd1, 32'h0000_0000);
        @(negedge clk); irq_in = 8'h04;
        repeat (5) @(posedge clk);
        rd_reg(4'd0, 32'h0000_0004);
        check("masked_irq", 32'(irq_out), 32'd0);
        rd_reg(4'd2, 32'h0000_0000);
        wr_reg(4'd1, 32'h0000_0004);
        check("unmasked_irq", 32'(irq_out), 32'd1);
        @(negedge clk); irq_in = '0;
        wr_reg(4'd1, 32'h0000_0000);

        // Unmapped indices
        wr_reg(4'd7, 32'hFFFF_FFFF);
        rd_reg(4'd7, 32'h0000_0000);
        rd_reg(4'd15, 32'h0000_0000);

`ifdef PIC_EDGE_EN
        wr_reg(4'd4, 32'h0000_0001);
        wr_reg(4'd1, 32'h0000_0001);
        rd_reg(4'd4, 32'h0000_0001);
        pulse0();
        rd_reg(4'd0, 32'h0000_0001);
        rd_reg(4'd2, 32'h8000_0000);
        rd_reg(4'd0, 32'h0000_0000);
        wr_reg(4'd3, 32'd0);
        // Collision: new rise lands on the CLAIM access edge
        pulse0();
        @(negedge clk); irq_in[0] = 1'b1;
        fork
            begin
                @(negedge clk);
                irq_in[0] = 1'b0;
            end
        join_none
        rd_reg(4'd2, 32'h8000_0000);
        rd_reg(4'd0, 32'h0000_0001);
        wr_reg(4'd3, 32'd0);
        wr_reg(4'd4, 32'h0000_0000);
        repeat (2) @(posedge clk);
        rd_reg(4'd0, 32'h0000_0000);
        wr_reg(4'd1, 32'h0000_0000);
`else
        wr_reg(4'd4, 32'h0000_0001);
        rd_reg(4'd4, 32'h0000_0000);
`endif

        // Abort: request up for a single sampling edge
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b1;
        bus.pic_evb_cmd_addr    = 4'd1;
        bus.pic_evb_cmd_wr      = 1'b1;
        bus.pic_evb_cmd_wr_data = 32'h0000_0033;
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b0;
        fin_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.pic_evb_cmd_finish === 1'b1) fin_seen++;
        end
        check("abort_no_finish", 32'(fin_seen), 32'd0);
        rd_reg(4'd1, 32'h0000_0000);

        // Reset pulse while finish is high
        wr_reg(4'd1, 32'h0000_000F);
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b1;
        bus.pic_evb_cmd_addr    = 4'd1;
        bus.pic_evb_cmd_wr      = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("pre_reset_finish", 32'(bus.pic_evb_cmd_finish), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_finish", 32'(bus.pic_evb_cmd_finish), 32'd0);
        @(negedge clk);
        bus.pic_evb_cmd_request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(4'd1, 32'h0000_0000);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
